// File: rtl/lu_result_fifo_if.sv
// Handshake bundle between a logic unit, the result FIFO and its consumer.
// The master modport is the environment side; the slave modport is the FIFO.
interface lu_result_fifo_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 2
);
  logic [DATA_WIDTH-1:0]  y_in;
  logic [OPCODE_SIZE-1:0] opcode_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [DATA_WIDTH-1:0]  data_out;
  logic [OPCODE_SIZE-1:0] opcode_out;
  logic                   zero_out;
  logic                   valid_out;
  logic                   ready_in;

  modport master (
    output y_in,
    output opcode_in,
    output valid_in,
    output ready_in,
    input  ready_out,
    input  data_out,
    input  opcode_out,
    input  zero_out,
    input  valid_out
  );

  modport slave (
    input  y_in,
    input  opcode_in,
    input  valid_in,
    input  ready_in,
    output ready_out,
    output data_out,
    output opcode_out,
    output zero_out,
    output valid_out
  );
endinterface

// File: rtl/lu_result_fifo.sv
// Result FIFO behind the logic unit: stores result, opcode and zero flag.
// Define LU_RESULT_PARITY_EN to add a stored per-entry parity and parity_out.
module lu_result_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 2,
  parameter int DEPTH       = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  lu_result_fifo_if.slave bus,
  output logic [CW-1:0] count_out,
`ifdef LU_RESULT_PARITY_EN
  output logic          parity_out,
`endif
  output logic          overflow_out
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } occ_e;

  occ_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
  logic [OPCODE_SIZE-1:0] op_mem   [DEPTH];
  logic                   zero_mem [DEPTH];
`ifdef LU_RESULT_PARITY_EN
  logic                   par_mem  [DEPTH];
`endif

  logic ready;
  logic valid;
  logic push;
  logic pop;

  // Handshake flags come straight from the occupancy state register.
  assign ready = (state_q != S_FULL);
  assign valid = (state_q != S_EMPTY);
  assign push  = bus.valid_in & ready;
  assign pop   = valid & bus.ready_in;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.valid_in & ~ready);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    unique case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        if (push && !pop &&
            count_q == CW'(DEPTH - 1)) begin
          state_d = S_FULL;
        end else if (pop && !push &&
                     count_q == CW'(1)) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_PARTIAL;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the read side is masked by valid.
  always_ff @(posedge clk_in) begin
    if (push && !rst_in) begin
      data_mem[wr_ptr_q] <= bus.y_in;
      op_mem[wr_ptr_q]   <= bus.opcode_in;
      zero_mem[wr_ptr_q] <= (bus.y_in == '0);
`ifdef LU_RESULT_PARITY_EN
      par_mem[wr_ptr_q]  <= ^bus.y_in;
`endif
    end
  end

  assign bus.ready_out  = ready;
  assign bus.valid_out  = valid;
  assign bus.data_out   = valid ? data_mem[rd_ptr_q] : '0;
  assign bus.opcode_out = valid ? op_mem[rd_ptr_q]   : '0;
  assign bus.zero_out   = valid & zero_mem[rd_ptr_q];
  assign count_out      = count_q;
  assign overflow_out   = overflow_q;

`ifdef LU_RESULT_PARITY_EN
  assign parity_out = valid & par_mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_lu_result_fifo.sv
// Self-checking bench for lu_result_fifo against a queue-based model.
// Parity checks are built only when LU_RESULT_PARITY_EN is defined.
module tb_lu_result_fifo;
  localparam int DW    = 8;
  localparam int OW    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lu_result_fifo_if #(.DATA_WIDTH(DW), .OPCODE_SIZE(OW)) bus ();

  logic [CW-1:0] count_out;
  logic          overflow_out;
`ifdef LU_RESULT_PARITY_EN
  logic          parity_out;
`endif

  lu_result_fifo #(
    .DATA_WIDTH(DW),
    .OPCODE_SIZE(OW),
    .DEPTH(DEPTH)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus),
    .count_out(count_out),
`ifdef LU_RESULT_PARITY_EN
    .parity_out(parity_out),
`endif
    .overflow_out(overflow_out)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [OW-1:0] op;
  } ent_t;

  ent_t q[$];
  bit   ovf;
  int   checks;
  int   errors;

  task automatic drive(bit v, logic [DW-1:0] y,
                       logic [OW-1:0] op, bit r);
    bus.valid_in  = v;
    bus.y_in      = y;
    bus.opcode_in = op;
    bus.ready_in  = r;
  endtask

  // One clock: the model applies the FIFO rules to the pre-edge inputs.
  task automatic cycle();
    bit   push, pop, ov;
    ent_t e;
    push = bus.valid_in && (q.size() < DEPTH);
    pop  = bus.ready_in && (q.size() > 0);
    ov   = bus.valid_in && (q.size() == DEPTH);
    e.d  = bus.y_in;
    e.op = bus.opcode_in;
    @(posedge clk);
    if (rst) begin
      q.delete();
      ovf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (ov) ovf = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, '0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 8'h3C, 2'b10, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, '0, '0, 0);
    checks++;
    if (count_out !== 3'd0 || bus.valid_out !== 1'b0 ||
        bus.data_out !== 8'h00 || bus.opcode_out !== 2'b00 ||
        bus.zero_out !== 1'b0 || overflow_out !== 1'b0 ||
        bus.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset cnt=%0d v=%b d=%h op=%b z=%b ovf=%b rdy=%b exp 0 0 00 00 0 0 1",
               count_out, bus.valid_out, bus.data_out, bus.opcode_out,
               bus.zero_out, overflow_out, bus.ready_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 8'hA5, 2'b01, 0);
    cycle();
    drive(0, '0, '0, 0);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hA5 ||
        bus.opcode_out !== 2'b01 || bus.zero_out !== 1'b0 ||
        count_out !== 3'd1) begin
      errors++;
      $display("FAIL basic v=%b d=%h op=%b z=%b cnt=%0d exp 1 a5 01 0 1",
               bus.valid_out, bus.data_out, bus.opcode_out,
               bus.zero_out, count_out);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] pat [4];
    pat = '{8'h00, 8'hFF, 8'h0F, 8'hF0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, pat[i], OW'(i), 0);
      cycle();
    end
    drive(0, '0, '0, 1);
    checks++;
    if (count_out !== 3'd4 || bus.ready_out !== 1'b0) begin
      errors++;
      $display("FAIL full cnt=%0d rdy=%b exp 4 0", count_out, bus.ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== pat[i] ||
          bus.opcode_out !== OW'(i) || bus.zero_out !== (i == 0)) begin
        errors++;
        $display("FAIL drain[%0d] v=%b d=%h op=%b z=%b exp 1 %h %b %b",
                 i, bus.valid_out, bus.data_out, bus.opcode_out,
                 bus.zero_out, pat[i], OW'(i), (i == 0));
      end
      cycle();
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 ||
        bus.opcode_out !== 2'b00 || bus.zero_out !== 1'b0) begin
      errors++;
      $display("FAIL drained v=%b d=%h op=%b z=%b exp all 0",
               bus.valid_out, bus.data_out, bus.opcode_out, bus.zero_out);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, DW'($urandom_range(0, 8'h54)), OW'($urandom), 0);
      cycle();
    end
    drive(1, 8'h55, 2'b11, 1);
    cycle();
    drive(0, '0, '0, 1);
    checks++;
    if (count_out !== 3'd3 || overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL overflow cnt=%0d ovf=%b exp 3 1", count_out, overflow_out);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.data_out !== q[0].d || bus.data_out === 8'h55) begin
        errors++;
        $display("FAIL ovf_drain[%0d] d=%h exp %h", i, bus.data_out, q[0].d);
      end
      cycle();
    end
    checks++;
    if (bus.valid_out !== 1'b0 || overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky v=%b ovf=%b exp 0 1", bus.valid_out, overflow_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, DW'($urandom), OW'($urandom), 0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (count_out !== 3'd2 || bus.data_out !== q[0].d ||
          bus.opcode_out !== q[0].op || overflow_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d] cnt=%0d d=%h op=%b ovf=%b exp 2 %h %b 0",
                 i, count_out, bus.data_out, bus.opcode_out,
                 overflow_out, q[0].d, q[0].op);
      end
      drive(1, DW'($urandom), OW'($urandom), 1);
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, DW'($urandom), OW'($urandom), 0);
      cycle();
    end
    drive(0, '0, '0, 1);
    cycle();
    drive(1, 8'h77, 2'b01, 0);
    checks++;
    if (count_out !== 3'd3 || overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst cnt=%0d ovf=%b exp 3 1", count_out, overflow_out);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, '0, '0, 0);
    checks++;
    if (count_out !== 3'd0 || bus.valid_out !== 1'b0 ||
        bus.data_out !== 8'h00 || overflow_out !== 1'b0 ||
        bus.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid cnt=%0d v=%b d=%h ovf=%b rdy=%b exp 0 0 00 0 1",
               count_out, bus.valid_out, bus.data_out,
               overflow_out, bus.ready_out);
    end
  endtask

  task automatic test_random();
    int            n;
    logic [DW-1:0] ed;
    logic [OW-1:0] eo;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom),
            OW'($urandom), $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 60) == 0);
      cycle();
      rst = 1'b0;
      n  = q.size();
      ed = (n > 0) ? q[0].d : '0;
      eo = (n > 0) ? q[0].op : '0;
      checks++;
      if (count_out !== CW'(n) || bus.valid_out !== (n > 0) ||
          bus.ready_out !== (n < DEPTH) || bus.data_out !== ed ||
          bus.opcode_out !== eo || bus.zero_out !== (n > 0 && ed == 0) ||
          overflow_out !== ovf) begin
        errors++;
        $display("FAIL rnd[%0d] cnt=%0d v=%b r=%b d=%h op=%b z=%b ovf=%b exp cnt=%0d d=%h op=%b ovf=%b",
                 c, count_out, bus.valid_out, bus.ready_out, bus.data_out,
                 bus.opcode_out, bus.zero_out, overflow_out, n, ed, eo, ovf);
      end
`ifdef LU_RESULT_PARITY_EN
      checks++;
      if (parity_out !== (n > 0 && ^ed)) begin
        errors++;
        $display("FAIL rnd_par[%0d] got=%b exp=%b", c, parity_out, (n > 0 && ^ed));
      end
`endif
    end
  endtask

`ifdef LU_RESULT_PARITY_EN
  task automatic test_parity();
    do_reset();
    drive(1, 8'h07, 2'b00, 0);
    cycle();
    drive(1, 8'h03, 2'b00, 0);
    cycle();
    drive(0, '0, '0, 1);
    checks++;
    if (parity_out !== 1'b1) begin
      errors++;
      $display("FAIL parity07 got=%b exp=1", parity_out);
    end
    cycle();
    checks++;
    if (parity_out !== 1'b0 || bus.data_out !== 8'h03) begin
      errors++;
      $display("FAIL parity03 got=%b d=%h exp=0 03", parity_out, bus.data_out);
    end
    cycle();
    checks++;
    if (parity_out !== 1'b0) begin
      errors++;
      $display("FAIL parity_empty got=%b exp=0", parity_out);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    ovf    = 1'b0;
    rst    = 1'b1;
    drive(0, '0, '0, 0);
    #1;
    test_reset();
    test_basic();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef LU_RESULT_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lu_result_fifo.md
LU_RESULT_FIFO -- requirements
Module: lu_result_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the logic-unit result.
REQ-002 Parameter OPCODE_SIZE, default 2: width of the opcode tag stored with each result.
REQ-003 Parameter DEPTH, default 4: number of entries; SHALL be a power of two and at least 2.
REQ-004 clk_in  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_in  input  1: reset, synchronous, active-high.
REQ-006 y_in  input  DATA_WIDTH: result from the upstream logic unit (y_out).
REQ-007 opcode_in  input  OPCODE_SIZE: opcode that produced y_in.
REQ-008 valid_in  input  1: y_in/opcode_in are valid this cycle.
REQ-009 ready_out  output  1: block can accept an entry (not full).
REQ-010 data_out  output  DATA_WIDTH: result at the head of the FIFO.
REQ-011 opcode_out  output  OPCODE_SIZE: opcode tag at the head.
REQ-012 zero_out  output  1: head result equals zero.
REQ-013 valid_out  output  1: head entry is valid (not empty).
REQ-014 ready_in  input  1: downstream consumer accepts the head this cycle.
REQ-015 count_out  output  log2(DEPTH)+1: number of stored entries, 0..DEPTH.
REQ-016 overflow_out  output  1: sticky flag; valid_in was seen while full.

Function
REQ-017 A push SHALL occur when valid_in && ready_out; a pop SHALL occur when valid_out && ready_in.
REQ-018 A push SHALL store y_in, opcode_in and the flag (y_in == 0) together in one entry.
REQ-019 ready_out SHALL be !(count == DEPTH), registered-equivalent, with no dependence on ready_in.
REQ-020 valid_out SHALL be (count != 0); write-to-valid_out latency is exactly 1 cycle; there is no bypass from input to output.
REQ-021 data_out, opcode_out and zero_out SHALL show the head entry while valid_out=1, and SHALL be all-zero while valid_out=0.
REQ-022 Occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
REQ-023 Transitions: push only -> count+1; pop only -> count-1; push and pop together -> count unchanged and both pointers advance.
REQ-024 EMPTY with simultaneous valid_in and ready_in: push only, because no pop is possible; the next cycle is PARTIAL with count=1.
REQ-025 FULL with valid_in and ready_in: pop only, because ready_out=0; the next cycle is PARTIAL with count=DEPTH-1 and the input is dropped.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH with no gap or duplicated entry at the wrap point.
REQ-027 valid_in=1 while ready_out=0 SHALL set overflow_out on the next edge; only rst_in clears it.
REQ-028 Entries SHALL leave in push order (FIFO); data is never modified while stored.

Reset
REQ-029 While rst_in=1 at a rising edge, the block SHALL clear the pointers, set count_out=0, valid_out=0 and overflow_out=0, and force data_out, opcode_out and zero_out to 0.
REQ-030 Reset during operation SHALL discard all stored entries; a push in the same cycle as reset SHALL be ignored.
REQ-031 After reset, ready_out SHALL be 1 in the first cycle in which rst_in=0.
REQ-032 Storage array contents need no reset; the outputs are masked by valid_out.

Configuration
REQ-033 Macro LU_RESULT_PARITY_EN, when defined, SHALL add output parity_out (1 bit) equal to the even parity (XOR-reduce) of the head data_out; parity_out is 0 when empty.
REQ-034 Parity SHALL be computed at push time and stored per entry, so it adds no combinational path after the read mux.
REQ-035 Without LU_RESULT_PARITY_EN, the parity_out port and the per-entry parity storage SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset, then push y_in=8'hA5 with opcode 2'b01 and ready_in=0 -> next cycle valid_out=1, data_out=8'hA5, opcode_out=2'b01, zero_out=0, count_out=1.
REQ-037 Push 8'h00, 8'hFF, 8'h0F, 8'hF0 with ready_in=0 -> count_out=4, ready_out=0; then hold ready_in=1 -> outputs 00(zero_out=1), FF, 0F, F0 in order, then valid_out=0 and outputs 0.
REQ-038 FULL, then drive valid_in=1 with y_in=8'h55 and ready_in=1 for one cycle -> 8'h55 is not stored, overflow_out=1 and stays 1, count_out=3.
REQ-039 Push and pop together every cycle for 10 cycles, starting at count=2 -> count_out stays 2, order is preserved across pointer wrap, and overflow_out=0.
REQ-040 Raise rst_in with count=3 and valid_in=1 -> next cycle count_out=0, valid_out=0, data_out=0, overflow_out=0, ready_out=1.
REQ-041 With LU_RESULT_PARITY_EN defined, push 8'h07 then 8'h03 -> parity_out=1 then 0; without the macro, the build has no parity_out port.
